// File: rtl/serial_add_nbit.sv
// Bit-serial N-bit adder: one result bit per clock through a single full-adder cell.
// Define SERIAL_ADD_OVF_EN to add the o_ovf signed-overflow output.

module full_half_add_1bit (
   input  logic i_a,
   input  logic i_b,
   input  logic i_cin,
   output logic o_sum,
   output logic o_carry
);
   assign o_sum   = i_a ^ i_b ^ i_cin;
   assign o_carry = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

module serial_add_nbit #(
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_cin,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_sum,
`ifdef SERIAL_ADD_OVF_EN
   output logic             o_carry,
   output logic             o_ovf
`else
   output logic             o_carry
`endif
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] a_sh, b_sh;
   logic [WIDTH-2:0] sum_sh;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic             cell_sum, cell_carry;
   logic [WIDTH-1:0] sum_full;
   logic             load, shift, finish;

   full_half_add_1bit u_cell (
      .i_a    (a_sh[0]),
      .i_b    (b_sh[0]),
      .i_cin  (carry),
      .o_sum  (cell_sum),
      .o_carry(cell_carry)
   );

   // Sum bits arrive LSB first, so the newest bit enters at the top.
   assign sum_full = {cell_sum, sum_sh};

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_nx = state;
      load     = 1'b0;
      shift    = 1'b0;
      finish   = 1'b0;
      case (state)
         S_IDLE, S_DONE: begin
            if (i_start) begin
               state_nx = S_RUN;
               load     = 1'b1;
            end else begin
               state_nx = S_IDLE;
            end
         end
         S_RUN: begin
            shift = 1'b1;
            if (cnt == CW'(WIDTH - 1)) begin
               state_nx = S_DONE;
               finish   = 1'b1;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state  <= S_IDLE;
         o_busy <= 1'b0;
         o_done <= 1'b0;
      end else begin
         state  <= state_nx;
         o_busy <= (state_nx == S_RUN);
         o_done <= (state_nx == S_DONE);
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         a_sh    <= '0;
         b_sh    <= '0;
         sum_sh  <= '0;
         cnt     <= '0;
         carry   <= 1'b0;
         o_sum   <= '0;
         o_carry <= 1'b0;
      end else begin
         if (load) begin
            a_sh  <= i_a;
            b_sh  <= i_b;
            carry <= i_cin;
            cnt   <= '0;
         end else if (shift) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            sum_sh <= sum_full[WIDTH-1:1];
            carry  <= cell_carry;
            cnt    <= cnt + CW'(1);
         end
         // Results are published only on the final RUN edge, never partially.
         if (finish) begin
            o_sum   <= sum_full;
            o_carry <= cell_carry;
         end
      end
   end

`ifdef SERIAL_ADD_OVF_EN
   // During the last RUN cycle the carry register holds the carry into the MSB.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_ovf <= 1'b0;
      end else if (finish) begin
         o_ovf <= carry ^ cell_carry;
      end
   end
`endif

endmodule

// File: tb/tb_serial_add_nbit.sv
// Self-checking bench for serial_add_nbit (WIDTH=8): vector table, corner sequences, random ops.

module tb_serial_add_nbit;

   localparam int W = 8;

   logic         i_clk = 1'b0;
   logic         i_rst = 1'b1;
   logic         i_start = 1'b0;
   logic [W-1:0] i_a = '0;
   logic [W-1:0] i_b = '0;
   logic         i_cin = 1'b0;
   logic         o_busy, o_done, o_carry;
   logic [W-1:0] o_sum;
   logic         o_ovf;

   int passed = 0;
   int total  = 0;

   serial_add_nbit #(.WIDTH(W)) dut (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_start(i_start),
      .i_a    (i_a),
      .i_b    (i_b),
      .i_cin  (i_cin),
      .o_busy (o_busy),
      .o_done (o_done),
      .o_sum  (o_sum),
`ifdef SERIAL_ADD_OVF_EN
      .o_carry(o_carry),
      .o_ovf  (o_ovf)
`else
      .o_carry(o_carry)
`endif
   );

`ifndef SERIAL_ADD_OVF_EN
   assign o_ovf = 1'b0;
`endif

   always #5 i_clk = ~i_clk;

   typedef struct {
      string        name;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic [W-1:0] sum;
      logic         carry;
      logic         ovf;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else passed++;
   endtask

   // Reference: plain integer arithmetic on the operands.
   function automatic logic [W:0] model_sum(input logic [W-1:0] a, b, input logic cin);
      return {1'b0, a} + {1'b0, b} + (W+1)'(cin);
   endfunction

   function automatic logic model_ovf(input logic [W-1:0] a, b, input logic cin);
      logic [W:0] s;
      s = model_sum(a, b, cin);
      return (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
   endfunction

   // Presents an operation and returns #1 after the accepting edge.
   task automatic start_op(input logic [W-1:0] a, b, input logic cin);
      @(negedge i_clk);
      i_a = a; i_b = b; i_cin = cin; i_start = 1'b1;
      @(posedge i_clk);
      #1;
      i_start = 1'b0;
   endtask

   // Counts edges from acceptance until o_done; lat = bound+1 on timeout.
   task automatic wait_done(input int bound, output int lat, output int busy_cnt);
      lat = bound + 1;
      busy_cnt = int'(o_busy);
      for (int c = 1; c <= bound; c++) begin
         @(posedge i_clk);
         #1;
         if (o_done) begin
            lat = c;
            break;
         end
         if (o_busy) busy_cnt++;
      end
   endtask

   vec_t vecs[4];
   int   lat, bcnt, dcnt, d1, d2;
   logic [W-1:0] cap_sum, ra, rb;
   logic         rc;
   logic [W:0]   exp_s;

   initial begin
      vecs[0] = '{"basic",   8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
      vecs[1] = '{"carry",   8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
      vecs[2] = '{"neg_ovf", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
      vecs[3] = '{"pos_ovf", 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1};

      // Reset state before any clock edge.
      #2;
      check("reset_outputs", {o_busy, o_done, o_carry, o_ovf, o_sum}, '0);
      @(negedge i_clk);
      i_rst = 1'b0;

      foreach (vecs[i]) begin
         start_op(vecs[i].a, vecs[i].b, vecs[i].cin);
         wait_done(20, lat, bcnt);
         check({vecs[i].name, "_latency"}, lat, 8);
         check({vecs[i].name, "_busy_cycles"}, bcnt, 8);
         check({vecs[i].name, "_sum"}, o_sum, vecs[i].sum);
         check({vecs[i].name, "_carry"}, o_carry, vecs[i].carry);
`ifdef SERIAL_ADD_OVF_EN
         check({vecs[i].name, "_ovf"}, o_ovf, vecs[i].ovf);
`endif
         @(posedge i_clk);
         #1;
         check({vecs[i].name, "_done_pulse"}, {o_done, o_busy}, 2'b00);
         check({vecs[i].name, "_hold"}, {o_carry, o_sum}, {vecs[i].carry, vecs[i].sum});
      end

      // Asynchronous reset between edges with the last result (0x80) still held.
      @(negedge i_clk);
      #2;
      i_rst = 1'b1;
      #1;
      check("async_reset", {o_busy, o_done, o_carry, o_ovf, o_sum}, '0);
      @(negedge i_clk);
      i_rst = 1'b0;

      // Busy protection: start pulse and operand changes mid-run are ignored.
      start_op(8'h12, 8'h34, 1'b0);
      repeat (2) @(posedge i_clk);
      #1;
      i_start = 1'b1; i_a = 8'hFF; i_b = 8'h77;
      @(posedge i_clk);
      #1;
      i_start = 1'b0;
      dcnt = 0;
      cap_sum = '0;
      for (int c = 0; c < 12; c++) begin
         @(posedge i_clk);
         #1;
         if (o_done) begin
            dcnt++;
            cap_sum = o_sum;
         end
      end
      check("busy_prot_done_count", dcnt, 1);
      check("busy_prot_sum", cap_sum, 8'h46);

      // Reset mid-operation; the previous result is held until the reset.
      start_op(8'hAA, 8'h55, 1'b0);
      check("hold_during_run", o_sum, 8'h46);
      repeat (4) @(posedge i_clk);
      #3;
      i_rst = 1'b1;
      #1;
      check("midrun_reset", {o_busy, o_done, o_carry, o_ovf, o_sum}, '0);
      @(negedge i_clk);
      i_rst = 1'b0;
      dcnt = 0;
      for (int c = 0; c < 12; c++) begin
         @(posedge i_clk);
         #1;
         if (o_done || o_busy) dcnt++;
      end
      check("midrun_reset_idle", dcnt, 0);
      start_op(8'h01, 8'h02, 1'b0);
      wait_done(20, lat, bcnt);
      check("after_reset_op", {lat, o_carry, o_sum}, {32'd8, 1'b0, 8'h03});

      // Back-to-back: start held through DONE is accepted on the edge ending DONE.
      @(negedge i_clk);
      i_a = 8'h10; i_b = 8'h20; i_cin = 1'b0; i_start = 1'b1;
      @(posedge i_clk);
      d1 = -1;
      d2 = -1;
      for (int c = 1; c <= 30; c++) begin
         @(posedge i_clk);
         #1;
         if (d1 >= 0 && c == d1 + 1) begin
            i_start = 1'b0;
            check("b2b_accept_busy", {o_busy, o_done}, 2'b10);
         end
         if (o_done) begin
            if (d1 < 0) begin
               d1 = c;
               check("b2b_first_sum", {o_carry, o_sum}, {1'b0, 8'h30});
               i_a = 8'h33; i_b = 8'h44;
            end else if (d2 < 0) begin
               d2 = c;
               check("b2b_second_sum", {o_carry, o_sum}, {1'b0, 8'h77});
            end
         end
      end
      i_start = 1'b0;
      check("b2b_first_latency", d1, 8);
      check("b2b_done_spacing", d2 - d1, 9);

      // Random operations against the arithmetic model.
      for (int n = 0; n < 100; n++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         rc = 1'($urandom);
         exp_s = model_sum(ra, rb, rc);
         start_op(ra, rb, rc);
         wait_done(20, lat, bcnt);
         check($sformatf("rand_%0d_%h_%h_%b", n, ra, rb, rc), {lat, o_carry, o_sum}, {32'd8, exp_s});
`ifdef SERIAL_ADD_OVF_EN
         check($sformatf("rand_ovf_%0d", n), o_ovf, model_ovf(ra, rb, rc));
`endif
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
